// File: rtl/ff_byte_packer_pkg.sv
// Shared definitions for the byte packer: default frame word widths, FSM
// state encoding and the byte-index width helper.
package ff_byte_packer_pkg;

    localparam int W1_DEF = 64;
    localparam int W2_DEF = 32;
    localparam int W3_DEF = 8;
    localparam int W4_DEF = 80;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Index width for a frame of tb bytes; never narrower than one bit.
    function automatic int idx_width(input int tb);
        return (tb > 1) ? $clog2(tb) : 1;
    endfunction

endpackage

// File: rtl/ff_byte_packer_shift.sv
// Frame assembly shift register: each accepted byte enters at the MSB end
// and the contents move right by one byte, so byte 0 lands in bits [7:0].
module ff_byte_packer_shift #(
    parameter int TB = 23
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            shift_en,
    input  logic [7:0]      din,
    output logic [TB*8-1:0] shifted
);

    logic [TB*8-1:0] q;

    generate
        if (TB > 1) begin : g_wide
            assign shifted = {din, q[TB*8-1:8]};
        end else begin : g_single
            assign shifted = din;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clr)
            q <= '0;
        else if (shift_en)
            q <= shifted;
    end

endmodule

// File: rtl/ff_byte_packer.sv
// Packs a valid/ready byte stream into one frame of four wide words and
// presents it on a valid/ready output for the wide-register ff stage.
//
// state | meaning
// FILL  | collecting frame bytes, idx = next byte position
// HOLD  | frame presented on d1..d4, waiting for out_ready
module ff_byte_packer
    import ff_byte_packer_pkg::*;
#(
    parameter int W1          = W1_DEF,
    parameter int W2          = W2_DEF,
    parameter int W3          = W3_DEF,
    parameter int W4          = W4_DEF,
    parameter bit STRICT_LAST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W1-1:0] d1,
    output logic [W2-1:0] d2,
    output logic [W3-1:0] d3,
    output logic [W4-1:0] d4,
    output logic [15:0]   frame_cnt,
    output logic          err_pulse
);

    localparam int TB = (W1 + W2 + W3 + W4) / 8;
    localparam int FW = TB * 8;
    localparam int IW = idx_width(TB);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            accept, load, discard, cnt_inc;
    logic [FW-1:0]   shifted, frame_q;
    logic [15:0]     frame_cnt_q;
    logic            err_q;

    // Handshake flags are forced low while reset is being applied.
    assign in_ready  = (state_q == FILL) && !rst;
    assign out_valid = (state_q == HOLD) && !rst;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        discard = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (idx_q == IW'(TB - 1)) begin
                        idx_d = '0;
                        if (in_last || !STRICT_LAST) begin
                            load    = 1'b1;
                            state_d = HOLD;
                        end else begin
                            discard = 1'b1;
                        end
                    end else if (in_last) begin
                        idx_d   = '0;
                        discard = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    cnt_inc = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    ff_byte_packer_shift #(.TB(TB)) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clr      (discard),
        .shift_en (accept),
        .din      (in_data),
        .shifted  (shifted)
    );

    // The output frame is captured only on completion, so partial bytes stay hidden.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q     <= '0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (load)
                frame_q <= shifted;
            frame_cnt_q <= frame_cnt_q + 16'(cnt_inc);
            err_q       <= discard;
        end
    end

    assign d1        = frame_q[W1-1:0];
    assign d2        = frame_q[W1+W2-1:W1];
    assign d3        = frame_q[W1+W2+W3-1:W1+W2];
    assign d4        = frame_q[FW-1:W1+W2+W3];
    assign frame_cnt = frame_cnt_q;
    assign err_pulse = err_q;

endmodule
